// File: rtl/mul_div_unit_pkg.sv
// Shared ISA definitions: R-type funct encodings for the HI/LO unit and the ALU.
package mul_div_unit_pkg;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef enum logic [5:0] {
        ALU_SLL  = 6'b000000,
        ALU_SRL  = 6'b000010,
        ALU_SRA  = 6'b000011,
        ALU_ADD  = 6'b100000,
        ALU_ADDU = 6'b100001,
        ALU_SUB  = 6'b100010,
        ALU_SUBU = 6'b100011,
        ALU_AND  = 6'b100100,
        ALU_OR   = 6'b100101,
        ALU_XOR  = 6'b100110,
        ALU_NOR  = 6'b100111,
        ALU_SLT  = 6'b101010,
        ALU_SLTU = 6'b101011
    } alu_funct_e;

    function automatic logic is_muldiv(input logic [5:0] f);
        return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [5:0] f);
        return (f == F_MULT) || (f == F_DIV);
    endfunction

    function automatic logic is_mul_op(input logic [5:0] f);
        return (f == F_MULT) || (f == F_MULTU);
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit: 32 shift-add / restoring-subtract steps,
// one sign-fix cycle, sharing a single 64-bit accumulator for both datapaths.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    import mul_div_unit_pkg::*;

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

    state_e               state_q, state_d;
    logic [5:0]           op_q;
    logic [WIDTH-1:0]     a_q, b_q, hi_q, lo_q;
    logic [2*WIDTH-1:0]   acc_q, acc_step, prod;
    logic                 sa_q, sb_q, done_q;
    logic [CW-1:0]        cnt_q;

    logic                 idle_req, accept, mt_write, req_signed;
    logic [WIDTH-1:0]     a_mag, b_mag, quot, rem, res_hi, res_lo;
    logic [WIDTH:0]       mul_sum, div_trial;

    // cancel outranks any request arriving in IDLE, including MTHI/MTLO
    assign idle_req   = (state_q == S_IDLE) && start && !cancel;
    assign accept     = idle_req && is_muldiv(funct);
    assign mt_write   = idle_req && ((funct == F_MTHI) || (funct == F_MTLO));
    assign req_signed = is_signed_op(funct);
    assign a_mag      = (req_signed && opA[WIDTH-1]) ? -opA : opA;
    assign b_mag      = (req_signed && opB[WIDTH-1]) ? -opB : opB;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN:   if (cancel) state_d = S_IDLE;
                     else if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = done_q;
        hi   = hi_q;
        lo   = lo_q;
    end

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
        div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
        if (is_mul_op(op_q))
            acc_step = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
        else // restoring step: borrow out means keep the shifted remainder, quotient bit 0
            acc_step = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
        quot = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        if (is_mul_op(op_q)) begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else if (b_q == '0) begin
            res_hi = a_q;
            res_lo = '1;
        end else begin
            res_hi = rem;
            res_lo = quot;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            acc_q  <= '0;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q  <= funct;
                        a_q   <= opA;
                        b_q   <= b_mag;
                        sa_q  <= req_signed & opA[WIDTH-1];
                        sb_q  <= req_signed & opB[WIDTH-1];
                        acc_q <= {{WIDTH{1'b0}}, a_mag};
                        cnt_q <= '0;
                    end else if (mt_write) begin
                        if (funct == F_MTHI) hi_q <= opA;
                        else                 lo_q <= opA;
                    end
                end
                S_RUN: if (!cancel) begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + 1'b1;
                end
                S_FIX: if (!cancel) begin
                    hi_q   <= res_hi;
                    lo_q   <= res_lo;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
